// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
//   Shared types and helpers for the serial shift sequencer.
//   - state_e     : FSM state encoding (2 bits)
//   - clog2_min1  : counter width helper that never returns 0
// Optional feature macro: SHIFT_SEQ_PARITY_EN (the PAR state is only reachable
// in that build; its encoding is always reserved).
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A counter for a single value still needs one flop.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_seq_bittimer.sv
// -----------------------------------------------------------------------------
// shift_seq_bittimer
//   Bit-time and bit-position counters for the shift sequencer.
//   div_cnt counts clks within a bit-time (0..DIV-1); bit_cnt counts bit-times
//   completed in the current frame and saturates at WIDTH.
// Ports
//   clk       in  clock, rising edge
//   rst       in  asynchronous reset, active low
//   clear_i   in  force both counters to 0 (has priority over run_i)
//   run_i     in  advance the counters this clk
//   bit_tick_o out last clk of the current bit-time (div_cnt==DIV-1)
//   last_bit_o out current bit-time is the final data bit (bit_cnt==WIDTH-1)
// -----------------------------------------------------------------------------
module shift_seq_bittimer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic run_i,
    output logic bit_tick_o,
    output logic last_bit_o
);

    localparam int DW = clog2_min1(DIV);
    localparam int BW = $clog2(WIDTH + 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    assign bit_tick_o = (div_cnt_q == DW'(DIV - 1));
    assign last_bit_o = (bit_cnt_q == BW'(WIDTH - 1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (clear_i) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (run_i) begin
            if (bit_tick_o) begin
                div_cnt_d = '0;
                // bit_cnt reaches WIDTH during the parity bit; hold it there.
                if (bit_cnt_q != BW'(WIDTH))
                    bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequencer for a serial shift datapath. Takes a parallel word over a
//   valid/ready handshake and shifts it out MSB-first, one bit per bit-time
//   (DIV clks), with so_valid qualifying every frame bit, busy while a frame
//   is in flight, a one-clk done pulse after an unaborted frame, and abort.
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   in_valid  in   producer has a word on in_data
//   in_ready  out  word can be accepted this clk (IDLE and no abort)
//   in_data   in   [WIDTH-1:0] parallel word, sampled on the accept edge only
//   abort     in   terminate the current frame (SHIFT or PAR)
//   so        out  serial data (registered)
//   so_valid  out  so carries a frame bit (registered)
//   busy      out  frame in progress (decoded from state)
//   done      out  end-of-frame pulse (registered)
// Build option
//   SHIFT_SEQ_PARITY_EN: append one even-parity bit-time (PAR state) after the
//   data bits. Without it, SHIFT goes straight to DONE. Ports are the same.
// -----------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             so_q, so_d;
    logic             so_valid_q, so_valid_d;
    logic             done_q, done_d;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept;
    logic run;
    logic bit_tick;
    logic last_bit;

    assign in_ready = (state_q == IDLE) && !abort;
    assign busy     = (state_q != IDLE);
    assign accept   = in_valid && in_ready;
    assign so       = so_q;
    assign so_valid = so_valid_q;
    assign done     = done_q;

    // Counters only advance while bits are on the line; everywhere else (and
    // on abort) they are held at zero so each frame starts from a clean count.
    assign run = (state_q == SHIFT) || (state_q == PAR);

    shift_seq_bittimer #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) u_bittimer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (!run || abort),
        .run_i      (run),
        .bit_tick_o (bit_tick),
        .last_bit_o (last_bit)
    );

    // so/so_valid/done are registered, so the next-state logic computes the
    // value they must show in the clk after the edge.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        so_d       = 1'b0;
        so_valid_d = 1'b0;
        done_d     = 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SHIFT;
                    shreg_d    = in_data;
                    so_d       = in_data[WIDTH-1];
                    so_valid_d = 1'b1;
`ifdef SHIFT_SEQ_PARITY_EN
                    par_d      = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    shreg_d = '0;
                end else if (bit_tick) begin
                    shreg_d = shreg_q << 1;
                    if (last_bit) begin
`ifdef SHIFT_SEQ_PARITY_EN
                        state_d    = PAR;
                        so_d       = par_q;
                        so_valid_d = 1'b1;
`else
                        state_d    = DONE;
                        done_d     = 1'b1;
`endif
                    end else begin
                        // Next bit is the one about to become the MSB.
                        so_d       = shreg_q[WIDTH-2];
                        so_valid_d = 1'b1;
                    end
                end else begin
                    so_d       = shreg_q[WIDTH-1];
                    so_valid_d = 1'b1;
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            PAR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_tick) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    so_d       = par_q;
                    so_valid_d = 1'b1;
                end
            end
`endif
            DONE: begin
                // abort is deliberately ignored here: the frame already finished.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            so_q       <= so_d;
            so_valid_q <= so_valid_d;
            done_q     <= done_d;
`ifdef SHIFT_SEQ_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule
